sdram_arbiter: RTL and testbench

Round-robin arbiter between the five SDRAM clients (load, mix, pitch, record, play) and the single SDRAM access port of `SDRAMBus`. It replaces the wired-OR request merge with a registered, single-owner grant. Each access is held stable until `SDRAMBus` reports completion, and that completion is routed back only to the owning client. It sits directly upstream of `SDRAMBus` and directly downstream of the processing cores.

---
 rtl/acappella_pkg.sv | 12 +
 rtl/rr_pick.sv | 21 ++
 rtl/sdram_arbiter.sv | 101 ++++++++++
 tb/tb_sdram_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/acappella_pkg.sv
// acappella_pkg: shared SDRAM widths, client indices and arbiter state type
package acappella_pkg;
  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;
  localparam int GRANT_W = 3;
  localparam int CLI_LOAD = 0;
  localparam int CLI_MIX = 1;
  localparam int CLI_PITCH = 2;
  localparam int CLI_RECORD = 3;
  localparam int CLI_PLAY = 4;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder, searching from last_grant+1
module rr_pick #(
  parameter int N = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N]) begin
        valid = 1'b1;
        idx = IDX_W'((int'(last_grant) + k) % N);
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin single-owner arbiter from the processing clients onto SDRAMBus
module sdram_arbiter
  import acappella_pkg::*;
#(
  parameter int N_CLIENTS = 5,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = SDRAM_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_CLIENTS-1:0]        cli_read,
  input  logic [N_CLIENTS-1:0]        cli_write,
  input  logic [N_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [N_CLIENTS*DATA_W-1:0] cli_writedata,
  output logic [N_CLIENTS-1:0]        cli_finished,
  output logic [DATA_W-1:0]           cli_readdata,
  output logic                        sdram_read,
  output logic                        sdram_write,
  output logic [ADDR_W-1:0]           sdram_addr,
  output logic [DATA_W-1:0]           sdram_writedata,
  input  logic [DATA_W-1:0]           sdram_readdata,
  input  logic                        sdram_finished,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        busy,
  output logic                        timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT) > 10 ? $clog2(TIMEOUT) : 10;
  arb_state_t state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, pick_idx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic wr_q, wr_d, timeout_err_q, timeout_err_d, pick_valid;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rr_pick #(.N(N_CLIENTS), .IDX_W(GRANT_W)) u_pick (
    .req(cli_read | cli_write),
    .last_grant(last_grant_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  always_comb begin
    state_d = state_q;
    grant_id_d = grant_id_q;
    last_grant_d = last_grant_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    timeout_err_d = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (pick_valid) begin
        state_d = ARB_BUSY;
        grant_id_d = pick_idx;
        addr_d = cli_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        wdata_d = cli_writedata[int'(pick_idx)*DATA_W +: DATA_W];
        wr_d = cli_write[pick_idx];
        cnt_d = '0;
      end
    end else if (sdram_finished) begin
      state_d = ARB_IDLE;
      last_grant_d = grant_id_q;
    end else if (cnt_q >= CNT_W'(TIMEOUT-1)) begin
      // completion in the same cycle takes the branch above, so no error is raised then
      state_d = ARB_IDLE;
      last_grant_d = grant_id_q;
      timeout_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      grant_id_q <= '0;
      last_grant_q <= GRANT_W'(N_CLIENTS-1);
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_id_q <= grant_id_d;
      last_grant_q <= last_grant_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign busy = state_q == ARB_BUSY;
  assign sdram_read = busy && !wr_q;
  assign sdram_write = busy && wr_q;
  assign sdram_addr = addr_q;
  assign sdram_writedata = wdata_q;
  assign grant_id = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign cli_readdata = sdram_readdata;
  assign cli_finished = (busy && sdram_finished) ? N_CLIENTS'(1) << grant_id_q : '0;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus with a per-cycle behavioural model of the arbiter
module tb_sdram_arbiter;
  localparam int N = 5, AW = 23, DW = 32, TMO = 16;
  logic i_clk = 0, i_rst = 1;
  logic [N-1:0] cli_read = '0, cli_write = '0, cli_finished;
  logic [N*AW-1:0] cli_addr = '0;
  logic [N*DW-1:0] cli_writedata = '0;
  logic [DW-1:0] cli_readdata, sdram_writedata, sdram_readdata = '0;
  logic [AW-1:0] sdram_addr;
  logic sdram_read, sdram_write, sdram_finished = 0, busy, timeout_err;
  logic [2:0] grant_id;
  int n_checks = 0, n_fail = 0;

  sdram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .cli_read(cli_read), .cli_write(cli_write),
    .cli_addr(cli_addr), .cli_writedata(cli_writedata), .cli_finished(cli_finished),
    .cli_readdata(cli_readdata), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_finished(sdram_finished), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cli(input int i, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_read[i] = rd;
    cli_write[i] = wr;
    cli_addr[i*AW +: AW] = a;
    cli_writedata[i*DW +: DW] = d;
  endtask

  // Model: who owns the port, what was latched at grant, and how long it has waited
  bit m_valid = 0, m_busy, m_wr, m_terr;
  int m_owner, m_last, m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  initial forever begin
    @(negedge i_clk);
    if (m_valid) begin
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, 64'(m_owner));
      chk("sdram_read", sdram_read, m_busy && !m_wr);
      chk("sdram_write", sdram_write, m_busy && m_wr);
      chk("timeout_err", timeout_err, m_terr);
      chk("cli_finished", cli_finished, (m_busy && sdram_finished) ? 64'(1) << m_owner : 64'(0));
      if (m_busy) begin
        chk("sdram_addr", sdram_addr, m_addr);
        chk("sdram_writedata", sdram_writedata, m_data);
      end
      if (m_busy && sdram_finished) chk("cli_readdata", cli_readdata, sdram_readdata);
    end
    if (i_rst) begin
      m_valid = 1; m_busy = 0; m_owner = 0; m_last = N-1; m_wr = 0; m_terr = 0; m_age = 0;
      m_addr = '0; m_data = '0;
    end else if (m_valid) begin
      m_terr = 0;
      if (!m_busy) begin
        for (int d = 1; d <= N; d++)
          if (!m_busy && (cli_read[(m_last+d)%N] || cli_write[(m_last+d)%N])) begin
            m_busy = 1;
            m_owner = (m_last+d)%N;
            m_wr = cli_write[m_owner];
            m_addr = cli_addr[m_owner*AW +: AW];
            m_data = cli_writedata[m_owner*DW +: DW];
            m_age = 0;
          end
      end else if (sdram_finished) begin
        m_busy = 0; m_last = m_owner;
      end else if (m_age == TMO-1) begin
        m_busy = 0; m_last = m_owner; m_terr = 1;
      end else m_age++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};
    int waited;
    tick(); tick();
    i_rst = 0;
    #2;
    chk("reset busy", busy, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset sdram_read", sdram_read, 0);
    chk("reset sdram_write", sdram_write, 0);
    chk("reset timeout_err", timeout_err, 0);
    // stray completion while idle must not reach any client
    sdram_finished = 1;
    #2 chk("idle finished ignored", cli_finished, 0);
    tick(); sdram_finished = 0;
    tick(); chk("idle stays idle", busy, 0);

    // single read by client 2, three BUSY cycles
    set_cli(2, 1, 0, 23'h000123, 0);
    tick(); #2 chk("rd cycle1 sdram_read", sdram_read, 1);
    chk("rd sdram_addr", sdram_addr, 23'h000123);
    tick(); #2 chk("rd cycle2 sdram_read", sdram_read, 1);
    tick(); sdram_finished = 1; sdram_readdata = 32'hDEADBEEF;
    #2 chk("rd cycle3 sdram_read", sdram_read, 1);
    chk("rd cli_finished", cli_finished, 5'b00100);
    chk("rd cli_readdata", cli_readdata, 32'hDEADBEEF);
    tick(); sdram_finished = 0; set_cli(2, 0, 0, 0, 0);
    #2 chk("rd released", sdram_read, 0);

    // round robin from reset, 1-cycle completions
    i_rst = 1; tick(); i_rst = 0;
    for (int i = 0; i < N; i++) set_cli(i, 1, 0, 23'(i*16), 0);
    for (int it = 0; it < 11; it++) begin
      tick();
      sdram_finished = busy;
      sdram_readdata = 32'hA0 + it;
      if (busy) order.push_back(int'(grant_id));
    end
    tick(); sdram_finished = 0; cli_read = '0;
    chk("rr grant count", 64'(order.size()), 6);
    foreach (exp_order[i]) if (i < order.size()) chk("rr grant order", 64'(order[i]), 64'(exp_order[i]));

    // write wins over read for the same client
    set_cli(3, 1, 1, 23'h7FFFFF, 32'h12345678);
    tick(); #2 chk("wp sdram_write", sdram_write, 1);
    chk("wp sdram_read", sdram_read, 0);
    chk("wp sdram_writedata", sdram_writedata, 32'h12345678);
    chk("wp grant_id", grant_id, 3);
    sdram_finished = 1;
    tick(); sdram_finished = 0; set_cli(3, 0, 0, 0, 0);

    // client address moves under an in-flight access
    set_cli(1, 1, 0, 23'h000ABC, 0);
    tick(); cli_addr[1*AW +: AW] = 23'h555555;
    #2 chk("stab addr t1", sdram_addr, 23'h000ABC);
    tick(); #2 chk("stab addr t2", sdram_addr, 23'h000ABC);
    sdram_finished = 1;
    tick(); sdram_finished = 0; set_cli(1, 0, 0, 0, 0);

    // timeout: client 4 granted first (after last=1), client 0 waits
    set_cli(4, 0, 1, 23'h000044, 32'hCAFE0004);
    set_cli(0, 1, 0, 23'h000100, 0);
    tick(); #2 chk("tmo grant_id", grant_id, 4);
    waited = 0;
    while (!timeout_err && waited < 40) begin tick(); waited++; end
    chk("tmo latency", 64'(waited), TMO);
    chk("tmo busy low", busy, 0);
    set_cli(4, 0, 0, 0, 0);
    tick(); #2 chk("tmo next grant", grant_id, 0);
    chk("tmo next busy", busy, 1);
    sdram_finished = 1;
    tick(); sdram_finished = 0; set_cli(0, 0, 0, 0, 0);

    // reset during the second BUSY cycle
    set_cli(2, 1, 0, 23'h000222, 0);
    set_cli(3, 1, 0, 23'h000333, 0);
    tick(); tick(); i_rst = 1;
    set_cli(0, 1, 0, 23'h000010, 0);
    tick(); #2 chk("mid-rst busy", busy, 0);
    chk("mid-rst sdram_read", sdram_read, 0);
    chk("mid-rst sdram_addr", sdram_addr, 0);
    chk("mid-rst grant_id", grant_id, 0);
    i_rst = 0;
    tick(); #2 chk("post-rst grant", grant_id, 0);
    chk("post-rst busy", busy, 1);
    sdram_finished = 1;
    tick(); sdram_finished = 0; cli_read = '0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
